funct_gen_queue: RTL

FUNCT_GEN_QUEUE -- requirements
Module: funct_gen_queue

---
 rtl/funct_gen_queue_if.sv | 25 ++
 rtl/funct_gen_queue.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/funct_gen_queue_if.sv
// Handshake bundle for funct_gen_queue: input instruction bundle side and
// decoded output bundle side. master = producer/consumer, slave = the queue.
interface funct_gen_queue_if #(
    parameter int LANES = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*32-1:0]   in_inst;
    logic [LANES-1:0]      in_mask;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*6-1:0]    out_funct;
    logic [LANES-1:0]      out_mask;
    logic [LANES-1:0]      out_illegal;

    modport master (
        output in_valid, in_inst, in_mask, out_ready,
        input  in_ready, out_valid, out_funct, out_mask, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_mask, out_ready,
        output in_ready, out_valid, out_funct, out_mask, out_illegal
    );
endinterface

// File: rtl/funct_gen_queue.sv
// Multi-lane MIPS funct generator feeding a DEPTH-entry bundle FIFO.
// Ports: clk, rst (sync high), flush, cfg_special2_en, bus (slave), illegal_cnt.
module funct_gen_queue #(
    parameter int LANES = 2,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 cfg_special2_en,
    funct_gen_queue_if.slave     bus,
    output logic [15:0]          illegal_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    localparam logic [5:0] FUNCT_NOP = 6'h00;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    // returns {illegal, funct}
    function automatic logic [6:0] decode(
        input logic [5:0] op,
        input logic [4:0] rt,
        input logic [5:0] fn,
        input logic       sp2_en
    );
        logic [5:0] f;
        logic       ill;
        f   = FUNCT_NOP;
        ill = 1'b0;
        unique case (op)
            6'h00: f = fn;
            6'h1c: begin
                if (!sp2_en) begin
                    ill = 1'b1;
                end else begin
                    unique case (fn)
                        6'h00, 6'h01, 6'h02, 6'h04,
                        6'h05, 6'h20, 6'h21: f = fn;
                        default:             ill = 1'b1;
                    endcase
                end
            end
            6'h01: begin
                unique case (rt)
                    5'h00, 5'h01: f = FUNCT_NOP;
                    5'h10, 5'h11: f = F_OR;
                    default:      ill = 1'b1;
                endcase
            end
            6'h0c:               f = F_AND;
            6'h0d, 6'h0f, 6'h03: f = F_OR;
            6'h0e:               f = F_XOR;
            6'h08,
            6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26,
            6'h28, 6'h29, 6'h2a, 6'h2b,
            6'h2e:               f = F_ADD;
            6'h09:               f = F_ADDU;
            6'h0a:               f = F_SLT;
            6'h0b:               f = F_SLTU;
            default:             f = FUNCT_NOP;
        endcase
        return {ill, f};
    endfunction

    logic [LANES*6-1:0] dec_funct;
    logic [LANES-1:0]   dec_ill;
    logic [2:0]         dec_pop;
    logic [6:0]         d;

    always_comb begin
        dec_funct = '0;
        dec_ill   = '0;
        dec_pop   = '0;
        d         = '0;
        for (int i = 0; i < LANES; i++) begin
            d = decode(bus.in_inst[32*i+26 +: 6],
                       bus.in_inst[32*i+16 +: 5],
                       bus.in_inst[32*i    +: 6],
                       cfg_special2_en);
            // masked-off lanes decode to a clean NOP
            if (bus.in_mask[i]) begin
                dec_funct[6*i +: 6] = d[5:0];
                dec_ill[i]          = d[6];
            end
            dec_pop = dec_pop + {2'b00, dec_ill[i]};
        end
    end

    logic unused_bits;
    assign unused_bits = ^bus.in_inst;

    logic [PW:0]   count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [16:0]   cnt_sum;
    logic [15:0]   cnt_next;

    logic [LANES*6-1:0] mem_funct [DEPTH];
    logic [LANES-1:0]   mem_mask  [DEPTH];
    logic [LANES-1:0]   mem_ill   [DEPTH];

    assign bus.in_ready  = count < DEPTH_C;
    assign bus.out_valid = count != '0;
    assign push = bus.in_valid & bus.in_ready & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    assign cnt_sum  = {1'b0, illegal_cnt} + {14'b0, dec_pop};
    assign cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            illegal_cnt <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + PTR_ONE;
                illegal_cnt <= cnt_next;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push & ~pop) begin
                count <= count + CNT_ONE;
            end else if (pop & ~push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push & ~rst) begin
            mem_funct[wr_ptr] <= dec_funct;
            mem_mask[wr_ptr]  <= bus.in_mask;
            mem_ill[wr_ptr]   <= dec_ill;
        end
    end

    // empty queue presents zeros, so storage itself needs no reset
    assign bus.out_funct   = bus.out_valid ? mem_funct[rd_ptr] : '0;
    assign bus.out_mask    = bus.out_valid ? mem_mask[rd_ptr]  : '0;
    assign bus.out_illegal = bus.out_valid ? mem_ill[rd_ptr]   : '0;
endmodule
